// File: rtl/mlp_layer_sequencer.sv
// Purpose: sequences one MLP inference (Stage2 clear, Stage1 row issue, Stage2 strobes aligned to the Stage1 latency).
// Latency: start accepted at cycle 0 -> s2_clear @1, row r @2+r, s2_enable r @2+r+S1_LAT, done @2+S1_NUM+S1_LAT.
// Backpressure: hold stalls the whole sequence with strobes masked; start_ready is low outside IDLE and while hold/abort.
// Ports: clk, reset (async, active-high); start_valid/start_ready request handshake; hold stall; abort cancel;
//        row_addr -> Stage1 weight mux; s2_clear, s2_enable, s2_row_idx -> Stage2 accumulator;
//        busy, done, frame_count -> status.
module mlp_layer_sequencer #(
   parameter int  S1_NUM    = 8,
   parameter int  S1_LAT    = 1,
   parameter int  CNT_WIDTH = 16,
   localparam int AW        = (S1_NUM > 1) ? $clog2(S1_NUM) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start_valid,
   output logic                 start_ready,
   input  logic                 hold,
   input  logic                 abort,
   output logic [AW-1:0]        row_addr,
   output logic                 s2_clear,
   output logic                 s2_enable,
   output logic [AW-1:0]        s2_row_idx,
   output logic                 busy,
   output logic                 done,
   output logic [CNT_WIDTH-1:0] frame_count
);

   typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, DRAIN, DONE} state_t;

   state_t state, state_nxt;
   logic   run;        // cycle advances: neither stalled nor cancelled
   logic   issue;      // a row is handed to Stage1 this cycle
   logic   last_row;
   logic   drain_end;  // only the output stage of the delay line is still occupied

   assign last_row = (row_addr == AW'(S1_NUM - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      run         = ~hold & ~abort;
      start_ready = (state == IDLE) & run;
      s2_clear    = (state == CLEAR) & run;
      issue       = (state == ISSUE) & run;
      done        = (state == DONE) & run;
      busy        = (state != IDLE);
      if (abort) begin
         state_nxt = IDLE;
      end else if (!hold) begin
         case (state)
            IDLE:    if (start_valid) state_nxt = CLEAR;
            CLEAR:   state_nxt = ISSUE;
            ISSUE:   if (last_row) state_nxt = (S1_LAT == 0) ? DONE : DRAIN;
            DRAIN:   if (drain_end) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // row_addr is zeroed on accept so it already reads 0 during CLEAR, and
   // stops on the last row so it holds that value once ISSUE is left.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         row_addr    <= '0;
         frame_count <= '0;
      end else begin
         if (start_ready && start_valid) row_addr <= '0;
         else if (issue && !last_row)    row_addr <= row_addr + 1'b1;
         if (done) frame_count <= frame_count + 1'b1;
      end
   end

   generate
      if (S1_LAT == 0) begin : g_nodl
         // Stage1 is combinational: the issued row is valid in the same cycle.
         assign s2_enable  = issue;
         assign s2_row_idx = row_addr;
         assign drain_end  = 1'b1;
      end else begin : g_dl
         // Stage [0] is loaded from the issue slot; stage [S1_LAT-1] lines up with s1_out.
         logic [S1_LAT-1:0] dl_vld;
         logic [AW-1:0]     dl_idx [S1_LAT];

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               dl_vld <= '0;
               for (int i = 0; i < S1_LAT; i++) dl_idx[i] <= '0;
            end else if (abort) begin
               dl_vld <= '0;
            end else if (!hold) begin
               dl_vld[0] <= issue;
               dl_idx[0] <= row_addr;
               for (int i = 1; i < S1_LAT; i++) begin
                  dl_vld[i] <= dl_vld[i-1];
                  dl_idx[i] <= dl_idx[i-1];
               end
            end
         end

         always_comb begin
            drain_end = 1'b1;
            for (int i = 0; i < S1_LAT - 1; i++)
               if (dl_vld[i]) drain_end = 1'b0;
         end

         assign s2_enable  = dl_vld[S1_LAT-1] & ~hold & ~abort;
         assign s2_row_idx = dl_idx[S1_LAT-1];
      end
   endgenerate

endmodule
